id2ex_stage: RTL and testbench
==============================

// Module: id2ex_stage
// PURPOSE
//  ID->EX pipeline register with hazard control. Captures decoded, already-forwarded operands from ID,
//  holds them while EX is busy, and inserts bubbles on load-use hazards and control flushes.
//  Generates the ID stall that freezes IF/ID, and provides the id2ex_rd_* fields used by ID forwarding.
// PARAMETERS
//  XLEN    64  datapath / PC width
//  CTRL_W  16  width of opaque EX control bundle (ALU op, word-op, mem size, etc.)
// PORTS
//  clk                        in   1       core clock
//  rst_n                      in   1       async active-low reset
//  id2ex_id_valid_i           in   1       ID holds a valid decoded instruction
//  id2ex_id_pc_i              in   XLEN    instruction PC
//  id2ex_id_rs1_data_i        in   XLEN    forwarded rs1 operand
//  id2ex_id_rs2_data_i        in   XLEN    forwarded rs2 operand
//  id2ex_id_imm_i             in   XLEN    sign-extended immediate
//  id2ex_id_ctrl_i            in   CTRL_W  EX control bundle
//  id2ex_id_rs1_en_i/rs2_en_i in   1 each  ID reads rs1/rs2
//  id2ex_id_rs1_index_i/rs2   in   5 each  ID source indices (`REG_INDEX_BUS)
//  id2ex_id_rd_en_i           in   1       ID writes rd
//  id2ex_id_rd_index_i        in   5       ID destination index
//  id2ex_id_load_i            in   1       ID instruction is a load
//  id2ex_id_jumpbranch_i      in   1       ID instruction is jump/branch (resolved in ID)
//  id2ex_ex2mem_load_i        in   1       instruction in EX/MEM register is a load
//  id2ex_ex2mem_rd_index_i    in   5       its rd
//  id2ex_ex_ready_i           in   1       EX accepts new instruction this cycle
//  id2ex_flush_i              in   1       kill instruction entering EX (redirect)
//  id2ex_valid_o              out  1       EX register holds a valid instruction
//  id2ex_pc_o/rs1_o/rs2_o/imm_o out XLEN   registered fields
//  id2ex_ctrl_o               out  CTRL_W  registered control
//  id2ex_rd_en_o              out  1       registered rd_en, gated by valid
//  id2ex_rd_index_o           out  5       registered rd
//  id2ex_load_o               out  1       registered load flag, gated by valid
//  id2ex_id_stall_o           out  1       freeze PC and IF/ID register
//  id2ex_stall_cnt_o          out  32      cycles with id_stall_o=1 (saturating)
//  id2ex_bubble_cnt_o         out  32      bubbles inserted (saturating)
// BEHAVIOUR
//  - Reset: all outputs 0; valid=0, counters=0.
//  - Load-use: luse = id_valid & id2ex_valid & id2ex_load & id2ex_rd_en & rd_index!=0
//    & ((rs1_en & rs1==rd) | (rs2_en & rs2==rd)).
//  - Branch-load: bload = id_valid & jumpbranch & ex2mem_load & ex2mem_rd!=0 & rs1/rs2 match (enabled).
//    Jump/branch resolve in ID, so a load one stage further still stalls one cycle.
//  - id_stall_o = luse | bload | (id_valid & ~ex_ready). Combinational, no latency.
//  - On each clk edge:
//    flush               -> valid<=0 (highest priority; also clears hazard-stall bubble)
//    ~ex_ready           -> hold all registers unchanged
//    luse|bload          -> valid<=0 (bubble), bubble_cnt++
//    else                -> load all fields from ID, valid<=id_valid
//  - Data fields are loaded only on accept; during bubble/flush they keep old values. rd_en_o and
//    load_o are ANDed with valid_o, so a stale bubble never forwards or raises a hazard.
//  - flush & ~ex_ready in the same cycle: flush wins; valid<=0.
//  - Counters saturate at 32'hFFFF_FFFF and do not wrap. stall_cnt counts cycles with id_stall_o=1.
//  - Reset asserted mid-stall: immediately valid=0 and stall deasserts combinationally (valid=0).
//  - rd index 0 never causes a hazard.
// STRUCTURE
//  - Shared defines.v: `REG_INDEX_BUS, `REG_INDEX_SIZE, `REG_BUS; add `ID2EX_CTRL_BUS.
//  - One sub-module, id2ex_hazard: combinational luse/bload/stall logic, kept separately testable.
//    Pipeline register and counters are in the top module.
// TESTING
//  1 Reset: rst_n=0 with random inputs -> all outputs 0; release -> first valid ID instr appears next cycle.
//  2 Load-use: lw x5 in EX, ID add x6,x5,x1 -> stall_o=1 one cycle, valid_o=0 next cycle,
//    add enters after; bubble_cnt=1.
//  3 Branch-load: lw x7 in ex2mem, ID beq x7,x0 -> one stall cycle. Repeat with rd=x0 -> no stall.
//  4 EX busy: ex_ready=0 for 3 cycles -> outputs frozen, stall_cnt=3, no bubble counted.
//  5 Flush: flush=1 together with ex_ready=0 and luse -> valid_o=0 next cycle;
//    rd_en_o=0 although rd_index_o is unchanged.
//  6 Saturation: preload counters near max via force -> they stop at FFFF_FFFF.

Source files
------------

// File: rtl/id2ex_pkg.sv
// Shared types and helpers for the ID->EX pipeline register and its hazard logic.
package id2ex_pkg;

    localparam int unsigned REG_INDEX_SIZE = 5;
    typedef logic [REG_INDEX_SIZE-1:0] reg_index_t;

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // What the EX register does on the next clock edge.
    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_FLUSH
    } id2ex_act_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != CNT_MAX) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/id2ex_hazard.sv
// Combinational load-use / branch-after-load / EX-busy stall detection for the ID stage.
module id2ex_hazard
    import id2ex_pkg::*;
(
    input  logic       id_valid,
    input  logic       rs1_en,
    input  reg_index_t rs1_index,
    input  logic       rs2_en,
    input  reg_index_t rs2_index,
    input  logic       jumpbranch,
    input  logic       ex_valid,
    input  logic       ex_load,
    input  logic       ex_rd_en,
    input  reg_index_t ex_rd_index,
    input  logic       ex2mem_load,
    input  reg_index_t ex2mem_rd_index,
    input  logic       ex_ready,
    output logic       luse,
    output logic       bload,
    output logic       stall
);

    // x0 is hard-wired zero, so it never carries a dependency.
    function automatic logic reads_reg(input reg_index_t rd);
        return (rd != '0) && ((rs1_en && rs1_index == rd) || (rs2_en && rs2_index == rd));
    endfunction

    always_comb begin
        luse  = id_valid && ex_valid && ex_load && ex_rd_en && reads_reg(ex_rd_index);
        bload = id_valid && jumpbranch && ex2mem_load && reads_reg(ex2mem_rd_index);
        stall = luse || bload || (id_valid && !ex_ready);
    end

endmodule

// File: rtl/id2ex_stage.sv
// ID->EX pipeline register: holds while EX is busy, bubbles on hazards, drops on flush,
// and counts stall cycles and inserted bubbles.
module id2ex_stage
    import id2ex_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id2ex_id_valid_i,
    input  logic [XLEN-1:0]   id2ex_id_pc_i,
    input  logic [XLEN-1:0]   id2ex_id_rs1_data_i,
    input  logic [XLEN-1:0]   id2ex_id_rs2_data_i,
    input  logic [XLEN-1:0]   id2ex_id_imm_i,
    input  logic [CTRL_W-1:0] id2ex_id_ctrl_i,
    input  logic              id2ex_id_rs1_en_i,
    input  logic              id2ex_id_rs2_en_i,
    input  reg_index_t        id2ex_id_rs1_index_i,
    input  reg_index_t        id2ex_id_rs2_index_i,
    input  logic              id2ex_id_rd_en_i,
    input  reg_index_t        id2ex_id_rd_index_i,
    input  logic              id2ex_id_load_i,
    input  logic              id2ex_id_jumpbranch_i,
    input  logic              id2ex_ex2mem_load_i,
    input  reg_index_t        id2ex_ex2mem_rd_index_i,
    input  logic              id2ex_ex_ready_i,
    input  logic              id2ex_flush_i,
    output logic              id2ex_valid_o,
    output logic [XLEN-1:0]   id2ex_pc_o,
    output logic [XLEN-1:0]   id2ex_rs1_o,
    output logic [XLEN-1:0]   id2ex_rs2_o,
    output logic [XLEN-1:0]   id2ex_imm_o,
    output logic [CTRL_W-1:0] id2ex_ctrl_o,
    output logic              id2ex_rd_en_o,
    output reg_index_t        id2ex_rd_index_o,
    output logic              id2ex_load_o,
    output logic              id2ex_id_stall_o,
    output logic [CNT_W-1:0]  id2ex_stall_cnt_o,
    output logic [CNT_W-1:0]  id2ex_bubble_cnt_o
);

    logic              valid_q;
    logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              rd_en_q, load_q;
    reg_index_t        rd_index_q;
    logic [CNT_W-1:0]  stall_cnt_q, bubble_cnt_q;

    logic       luse, bload, hz_stall;
    id2ex_act_e act;

    id2ex_hazard u_hazard (
        .id_valid        (id2ex_id_valid_i),
        .rs1_en          (id2ex_id_rs1_en_i),
        .rs1_index       (id2ex_id_rs1_index_i),
        .rs2_en          (id2ex_id_rs2_en_i),
        .rs2_index       (id2ex_id_rs2_index_i),
        .jumpbranch      (id2ex_id_jumpbranch_i),
        .ex_valid        (id2ex_valid_o),
        .ex_load         (id2ex_load_o),
        .ex_rd_en        (id2ex_rd_en_o),
        .ex_rd_index     (id2ex_rd_index_o),
        .ex2mem_load     (id2ex_ex2mem_load_i),
        .ex2mem_rd_index (id2ex_ex2mem_rd_index_i),
        .ex_ready        (id2ex_ex_ready_i),
        .luse            (luse),
        .bload           (bload),
        .stall           (hz_stall)
    );

    // Stall is forced low while in reset so every output reads zero.
    assign id2ex_id_stall_o = rst_n && hz_stall;

    always_comb begin
        act = ACT_LOAD;
        if (id2ex_flush_i)          act = ACT_FLUSH;
        else if (!id2ex_ex_ready_i) act = ACT_HOLD;
        else if (luse || bload)     act = ACT_BUBBLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            ctrl_q       <= '0;
            rd_en_q      <= 1'b0;
            rd_index_q   <= '0;
            load_q       <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: valid_q <= 1'b0;
                ACT_HOLD: ;
                ACT_LOAD: begin
                    valid_q    <= id2ex_id_valid_i;
                    pc_q       <= id2ex_id_pc_i;
                    rs1_q      <= id2ex_id_rs1_data_i;
                    rs2_q      <= id2ex_id_rs2_data_i;
                    imm_q      <= id2ex_id_imm_i;
                    ctrl_q     <= id2ex_id_ctrl_i;
                    rd_en_q    <= id2ex_id_rd_en_i;
                    rd_index_q <= id2ex_id_rd_index_i;
                    load_q     <= id2ex_id_load_i;
                end
                default: ;
            endcase
            stall_cnt_q  <= sat_inc(stall_cnt_q, id2ex_id_stall_o);
            bubble_cnt_q <= sat_inc(bubble_cnt_q, act == ACT_BUBBLE);
        end
    end

    assign id2ex_valid_o      = valid_q;
    assign id2ex_pc_o         = pc_q;
    assign id2ex_rs1_o        = rs1_q;
    assign id2ex_rs2_o        = rs2_q;
    assign id2ex_imm_o        = imm_q;
    assign id2ex_ctrl_o       = ctrl_q;
    assign id2ex_rd_en_o      = valid_q && rd_en_q;
    assign id2ex_rd_index_o   = rd_index_q;
    assign id2ex_load_o       = valid_q && load_q;
    assign id2ex_stall_cnt_o  = stall_cnt_q;
    assign id2ex_bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id2ex_stage.sv
// Directed and randomized checks of id2ex_stage against a cycle-level behavioural model.
module tb_id2ex_stage;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CTRL_W = 16;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, rs1_en, rs2_en, rd_en, ld, jb, e2m_load, ex_ready, flush;
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0] rs1i, rs2i, rdi, e2m_rd;

    logic valid_o, rd_en_o, load_o, stall_o;
    logic [XLEN-1:0] pc_o, rs1_o, rs2_o, imm_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [4:0] rd_index_o;
    logic [31:0] stall_cnt_o, bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    // Model of the instruction sitting in EX, plus event counters.
    logic m_valid, m_rd_en, m_load;
    logic [XLEN-1:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [CTRL_W-1:0] m_ctrl;
    logic [4:0] m_rd;
    longint m_stall_cnt, m_bubble_cnt;

    id2ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id2ex_id_valid_i(id_valid), .id2ex_id_pc_i(pc),
        .id2ex_id_rs1_data_i(rs1d), .id2ex_id_rs2_data_i(rs2d),
        .id2ex_id_imm_i(imm), .id2ex_id_ctrl_i(ctrl),
        .id2ex_id_rs1_en_i(rs1_en), .id2ex_id_rs2_en_i(rs2_en),
        .id2ex_id_rs1_index_i(rs1i), .id2ex_id_rs2_index_i(rs2i),
        .id2ex_id_rd_en_i(rd_en), .id2ex_id_rd_index_i(rdi),
        .id2ex_id_load_i(ld), .id2ex_id_jumpbranch_i(jb),
        .id2ex_ex2mem_load_i(e2m_load), .id2ex_ex2mem_rd_index_i(e2m_rd),
        .id2ex_ex_ready_i(ex_ready), .id2ex_flush_i(flush),
        .id2ex_valid_o(valid_o), .id2ex_pc_o(pc_o), .id2ex_rs1_o(rs1_o),
        .id2ex_rs2_o(rs2_o), .id2ex_imm_o(imm_o), .id2ex_ctrl_o(ctrl_o),
        .id2ex_rd_en_o(rd_en_o), .id2ex_rd_index_o(rd_index_o),
        .id2ex_load_o(load_o), .id2ex_id_stall_o(stall_o),
        .id2ex_stall_cnt_o(stall_cnt_o), .id2ex_bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rd_en = 0; m_load = 0; m_pc = '0; m_rs1 = '0; m_rs2 = '0;
        m_imm = '0; m_ctrl = '0; m_rd = '0; m_stall_cnt = 0; m_bubble_cnt = 0;
    endtask

    function automatic bit id_reads(input logic [4:0] r);
        return (r != 0) && ((rs1_en && rs1i == r) || (rs2_en && rs2i == r));
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "/valid"}, valid_o, m_valid);
        chk({tag, "/pc"}, pc_o, m_pc);
        chk({tag, "/rs1"}, rs1_o, m_rs1);
        chk({tag, "/rs2"}, rs2_o, m_rs2);
        chk({tag, "/imm"}, imm_o, m_imm);
        chk({tag, "/ctrl"}, ctrl_o, m_ctrl);
        chk({tag, "/rd_en"}, rd_en_o, m_valid & m_rd_en);
        chk({tag, "/rd"}, rd_index_o, m_rd);
        chk({tag, "/load"}, load_o, m_valid & m_load);
        chk({tag, "/stall_cnt"}, stall_cnt_o, m_stall_cnt);
        chk({tag, "/bubble_cnt"}, bubble_cnt_o, m_bubble_cnt);
    endtask

    // Called just after a rising edge with inputs already applied; runs one full cycle.
    task automatic tick(input string tag);
        bit hazard, exp_stall;
        #1;
        hazard = id_valid && ((m_valid && m_load && m_rd_en && id_reads(m_rd)) ||
                              (jb && e2m_load && id_reads(e2m_rd)));
        exp_stall = hazard || (id_valid && !ex_ready);
        chk({tag, "/stall"}, stall_o, exp_stall);
        if (exp_stall && m_stall_cnt < CMAX) m_stall_cnt++;
        if (flush) m_valid = 0;
        else if (ex_ready) begin
            if (hazard) begin
                m_valid = 0;
                if (m_bubble_cnt < CMAX) m_bubble_cnt++;
            end else begin
                m_valid = id_valid; m_pc = pc; m_rs1 = rs1d; m_rs2 = rs2d; m_imm = imm;
                m_ctrl = ctrl; m_rd_en = rd_en; m_rd = rdi; m_load = ld;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_id(input logic [XLEN-1:0] p, input logic r1e, input logic [4:0] r1,
                          input logic r2e, input logic [4:0] r2, input logic rde,
                          input logic [4:0] rd, input logic l, input logic j);
        id_valid = 1; pc = p; rs1d = {$urandom, $urandom}; rs2d = {$urandom, $urandom};
        imm = {$urandom, $urandom}; ctrl = CTRL_W'($urandom);
        rs1_en = r1e; rs1i = r1; rs2_en = r2e; rs2i = r2; rd_en = rde; rdi = rd; ld = l; jb = j;
        ex_ready = 1; flush = 0; e2m_load = 0; e2m_rd = '0;
    endtask

    task automatic rand_inputs();
        id_valid = ($urandom % 8) != 0;
        pc = {$urandom, $urandom}; rs1d = {$urandom, $urandom}; rs2d = {$urandom, $urandom};
        imm = {$urandom, $urandom}; ctrl = CTRL_W'($urandom);
        rs1_en = $urandom % 2; rs2_en = $urandom % 2;
        rs1i = 5'($urandom % 4); rs2i = 5'($urandom % 4); rdi = 5'($urandom % 4);
        rd_en = ($urandom % 4) != 0; ld = $urandom % 2; jb = ($urandom % 4) == 0;
        e2m_load = $urandom % 2; e2m_rd = 5'($urandom % 4);
        ex_ready = ($urandom % 4) != 0; flush = ($urandom % 10) == 0;
    endtask

    initial begin
        longint s0, b0;
        // Reset with random inputs: every output reads zero.
        rst_n = 0;
        rand_inputs();
        id_valid = 1; ex_ready = 0;
        model_reset();
        #2;
        chk("reset/stall", stall_o, 0);
        check_outputs("reset");
        @(posedge clk); #1;
        check_outputs("reset2");
        rst_n = 1;

        // First valid instruction appears the cycle after reset release.
        set_id(64'h1000, 1, 5'd2, 0, 5'd0, 1, 5'd3, 0, 0);
        tick("first");
        chk("first/valid_o", valid_o, 1);

        // Load-use: lw x5 then add x6,x5,x1.
        set_id(64'h1004, 1, 5'd2, 0, 5'd0, 1, 5'd5, 1, 0);
        tick("lw");
        set_id(64'h1008, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0);
        tick("luse");
        chk("luse/bubble", valid_o, 0);
        tick("add");
        chk("add/pc", pc_o, 64'h1008);
        chk("add/bubble_cnt", bubble_cnt_o, 1);

        // Branch after load one stage further: beq x7,x0 with lw x7 in EX/MEM.
        set_id(64'h100c, 1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 1);
        e2m_load = 1; e2m_rd = 5'd7;
        tick("bload");
        e2m_load = 0;
        tick("bload_go");
        set_id(64'h1010, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 1);
        e2m_load = 1; e2m_rd = 5'd0;
        tick("bload_x0");
        chk("bload_x0/valid_o", valid_o, 1);

        // EX busy for three cycles: frozen, stalls counted, no bubble.
        s0 = m_stall_cnt; b0 = m_bubble_cnt;
        set_id(64'h1014, 1, 5'd1, 0, 5'd0, 1, 5'd4, 0, 0);
        ex_ready = 0;
        repeat (3) tick("busy");
        chk("busy/stall_cnt", stall_cnt_o, s0 + 3);
        chk("busy/bubble_cnt", bubble_cnt_o, b0);

        // Flush beats EX-busy and load-use together.
        set_id(64'h1018, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0);
        tick("flush_lw");
        set_id(64'h101c, 1, 5'd5, 0, 5'd0, 1, 5'd8, 0, 0);
        ex_ready = 0; flush = 1;
        tick("flush");
        chk("flush/valid_o", valid_o, 0);
        chk("flush/rd_en_o", rd_en_o, 0);
        chk("flush/rd_index_o", rd_index_o, 5'd5);

        // Saturation: preload counters just below the top.
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        release dut.bubble_cnt_q;
        m_stall_cnt = 64'hFFFF_FFFD; m_bubble_cnt = 64'hFFFF_FFFE;
        set_id(64'h1020, 1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 1);
        e2m_load = 1; e2m_rd = 5'd9;
        repeat (4) tick("sat");
        chk("sat/stall_cnt", stall_cnt_o, 32'hFFFF_FFFF);
        chk("sat/bubble_cnt", bubble_cnt_o, 32'hFFFF_FFFF);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            tick($sformatf("rnd%0d", i));
        end

        // Reset asserted in the middle of a load-use stall.
        set_id(64'h2000, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0);
        tick("mid_lw");
        set_id(64'h2004, 1, 5'd5, 0, 5'd0, 1, 5'd6, 0, 0);
        #1;
        chk("mid/stall_before", stall_o, 1);
        rst_n = 0;
        #1;
        chk("mid/stall_after", stall_o, 0);
        chk("mid/valid", valid_o, 0);
        model_reset();
        @(posedge clk); #1;
        check_outputs("mid_reset");
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
